// File: rtl/ftdi_io_enc.sv
// Byte-to-serial encoder for the FTDI link: a small FIFO feeds an MSB-first shifter,
// and idle filler bytes are sent whenever no data is queued at a byte boundary.
module ftdi_io_enc #(
  parameter int         CFifoDepth = 4,
  parameter logic [7:0] CIdleByte  = 8'hFF
) (
  input  logic       AClkH,
  input  logic       AResetH,
  input  logic       ABitEn,
  input  logic [7:0] ADataI,
  input  logic       AValidI,
  output logic       AReadyO,
  output logic       ADataO,
  output logic       AByteEndO,
  output logic       ABusyO,
  output logic [7:0] AGapCntO
);

  localparam int             LAw      = (CFifoDepth > 1) ? $clog2(CFifoDepth) : 1;
  localparam logic [LAw:0]   LFull    = (LAw + 1)'(CFifoDepth);
  localparam logic [LAw:0]   LCntOne  = (LAw + 1)'(1);
  localparam logic [LAw-1:0] LPtrOne  = LAw'(1);

  typedef enum logic {SIdle, SData} state_t;

  logic [7:0]     r_mem [CFifoDepth];
  logic [LAw-1:0] r_wrPtr, r_rdPtr;
  logic [LAw:0]   r_count;
  logic [2:0]     r_bitCnt;
  logic [7:0]     r_sReg;
  logic           r_dataO, r_byteEnd;
  logic [7:0]     r_gapCnt;
  state_t         r_state, w_stateNext;

  logic       w_full, w_empty, w_wr, w_load, w_rd, w_gapInc;
  logic [7:0] w_loadByte;

  assign w_full  = (r_count == LFull);
  assign w_empty = (r_count == '0);
  assign w_wr    = AValidI && !w_full;
  assign w_load  = ABitEn && (r_bitCnt == 3'd0);

  assign AReadyO   = !w_full;
  assign ADataO    = r_dataO;
  assign AByteEndO = r_byteEnd;
  assign ABusyO    = !w_empty || (r_state == SData);
  assign AGapCntO  = r_gapCnt;

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) r_state <= SIdle;
    else         r_state <= w_stateNext;
  end

  // At a load, pop the head byte if one is queued; otherwise fall back to the idle filler.
  always_comb begin
    w_stateNext = r_state;
    w_loadByte  = CIdleByte;
    w_rd        = 1'b0;
    w_gapInc    = 1'b0;
    if (w_load) begin
      if (!w_empty) begin
        w_rd        = 1'b1;
        w_loadByte  = r_mem[r_rdPtr];
        w_stateNext = SData;
      end else if (r_state == SData) begin
        w_gapInc    = 1'b1;
        w_stateNext = SIdle;
      end
    end
  end

  always_ff @(posedge AClkH) begin
    if (w_wr) r_mem[r_wrPtr] <= ADataI;
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wrPtr <= r_wrPtr + LPtrOne;
      if (w_rd) r_rdPtr <= r_rdPtr + LPtrOne;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + LCntOne;
        2'b01:   r_count <= r_count - LCntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serial shifter; everything holds while the bit strobe is low.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_bitCnt  <= 3'd0;
      r_sReg    <= 8'h00;
      r_dataO   <= CIdleByte[7];
      r_byteEnd <= 1'b0;
      r_gapCnt  <= 8'h00;
    end else begin
      r_byteEnd <= ABitEn && (r_bitCnt == 3'd7);
      if (ABitEn) begin
        r_bitCnt <= r_bitCnt + 3'd1;
        if (w_load) begin
          r_dataO <= w_loadByte[7];
          r_sReg  <= {w_loadByte[6:0], 1'b0};
        end else begin
          r_dataO <= r_sReg[7];
          r_sReg  <= {r_sReg[6:0], 1'b0};
        end
      end
      if (w_gapInc && (r_gapCnt != 8'hFF)) r_gapCnt <= r_gapCnt + 8'd1;
    end
  end

endmodule
